dst_mac_seq: RTL and testbench
==============================

# dst_mac_seq

Sequential, parametrised multiply-accumulate engine for the DST datapath. It computes one N-term dot product y = Σ c[k]·x[k] per vector. Sample/coefficient pairs arrive one beat per cycle on a valid/ready stream, and each result leaves on a valid/ready output stream. Over the combinational 4-tap MAC it adds:
- an arbitrary tap count N;
- a pipelined, time-multiplexed multiplier;
- round-half-up output scaling and saturation to a narrower output;
- backpressure and a synchronous flush.

## Interface
- IN_W, 12, signed sample width
- COEFF_W, 8, signed coefficient width
- N, 4, taps per vector (≥2)
- SHIFT, 0, arithmetic right shift applied to the final sum (0..IN_W+COEFF_W)
- OUT_W, IN_W+COEFF_W+2, signed result width; narrower than the accumulator means saturating
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discards any partial vector
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_x  in  IN_W  signed sample
- s_c  in  COEFF_W  signed coefficient
- m_valid  out  1  result valid
- m_ready  in  1  result accepted when m_valid & m_ready
- m_y  out  OUT_W  signed result
- m_sat  out  1  result was clamped

## Operation
- **Widths**
  - Product P = IN_W+COEFF_W bits.
  - Accumulator A = IN_W+COEFF_W+$clog2(N) bits, exact with no overflow for any inputs.
- **Global advance enable:** en = ~(m_valid & ~m_ready).
  - s_ready = en & ~flush.
  - All pipeline registers update only when en=1.
- **Stage 1** (on an accepted beat):
  - prod_r = s_x·s_c, signed.
  - vld1 = 1, last1 = (beat_cnt == N-1).
  - beat_cnt increments and wraps N-1 → 0.
- **Stage 2** (when vld1):
  - sum = acc + prod_r, computed at A bits.
  - If last1 = 0: acc = sum.
  - If last1 = 1: acc = 0 and the output register is loaded (next vector's first product can accumulate with no bubble).
- **Output scaling**
  - If SHIFT > 0: r = (sum + 2^(SHIFT-1)) >>> SHIFT, computed at A+1 bits.
  - Else: r = sum.
- **Saturation**
  - If r > 2^(OUT_W-1)-1 or r < -2^(OUT_W-1): m_y = that bound, m_sat = 1.
  - Else: m_y = r, m_sat = 0.
- **Output register**
  - m_valid sets on load and clears on handshake with no new load.
  - Handshake and a new load on the same edge: the new result replaces the old one and m_valid stays 1.
- **Flush** (synchronous)
  - Clears beat_cnt, acc, vld1 and last1.
  - Does not touch m_valid, m_y or m_sat, so a pending result is still delivered.
  - A beat presented in the flush cycle is not accepted (s_ready=0).
- **Reset** (asynchronous, any time, including mid-vector)
  - Outputs: m_valid=0, m_y=0, m_sat=0.
  - Internal state: beat_cnt=0, acc=0, vld1=0, last1=0, prod_r=0.
  - s_ready=1 once m_valid=0 and flush=0.

## Timing
- Throughput: one beat per cycle; one result every N cycles with continuous input.
- Latency: last beat accepted in cycle T → m_valid=1 and m_y valid in cycle T+2.
- Stall: while m_valid=1 and m_ready=0, s_ready=0 and stage 1, stage 2 and acc hold; nothing is lost or duplicated.
- m_ready may be tied high; results then stream with no stall.
- s_x/s_c are sampled only on accepted beats; values on non-accepted cycles are ignored.
- No combinational path from s_valid to s_ready; s_ready depends only on m_valid, m_ready and flush.

## Test plan
- **Basic vector** (defaults): x={1,2,3,4}, c={5,6,7,8}, back-to-back → m_y=70, m_sat=0, m_valid two cycles after the 4th beat.
- **Extremes** (defaults): all x=-2048, c=-128 → m_y=1048576, m_sat=0. Then x=2047, c=-128 ×4 → m_y=-1048064.
- **Saturation and rounding**
  - OUT_W=16, extreme vector → m_y=32767, m_sat=1.
  - SHIFT=4, basic vector → m_y=4; negated coefficients (sum -70) → m_y=-4.
- **Backpressure**
  - Three consecutive vectors; hold m_ready=0 for 5 cycles after the first result → s_ready=0 during the hold.
  - Results 70, -70, 70 delivered in order, each exactly once.
- **Flush**
  - Flush after 2 beats, then a full basic vector → m_y=70.
  - Flush while a result is pending → that result is still delivered.
- **Reset mid-vector**
  - Assert rst_n=0 after beat 3 → m_valid=0 and m_y=0 immediately.
  - After release, a basic vector → 70.

Source files
------------

// File: rtl/dst_mac_seq.sv
// -----------------------------------------------------------------------------
// dst_mac_seq
//   Sequential multiply-accumulate engine for the DST datapath. Computes one
//   N-term dot product y = sum(c[k]*x[k]) per vector from a stream of
//   sample/coefficient beats. The result is rounded (round-half-up),
//   arithmetically right-shifted by SHIFT and saturated to OUT_W bits.
//
//   Pipeline: beat counter (p0) -> registered product (p1) -> accumulator (p2)
//             -> output register (m_*).
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   flush    : synchronous; discards any partial vector, keeps a pending result
//   s_valid  : input beat valid
//   s_ready  : input beat accepted when s_valid & s_ready
//   s_x      : signed sample, IN_W bits
//   s_c      : signed coefficient, COEFF_W bits
//   m_valid  : result valid
//   m_ready  : result accepted when m_valid & m_ready
//   m_y      : signed result, OUT_W bits
//   m_sat    : result was clamped
// -----------------------------------------------------------------------------
module dst_mac_seq #(
    parameter int IN_W    = 12,
    parameter int COEFF_W = 8,
    parameter int N       = 4,
    parameter int SHIFT   = 0,
    parameter int OUT_W   = IN_W + COEFF_W + 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic signed [IN_W-1:0]    s_x,
    input  logic signed [COEFF_W-1:0] s_c,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic signed [OUT_W-1:0]   m_y,
    output logic                      m_sat
);

    localparam int P  = IN_W + COEFF_W;
    localparam int CW = $clog2(N);
    localparam int A  = P + CW;
    // Width wide enough to hold both the scaled sum and the output bounds.
    localparam int WW = (A + 1 > OUT_W) ? A + 1 : OUT_W;

    // Half an output LSB; collapses to zero when SHIFT == 0.
    localparam logic signed [A:0]    RND  = ((A + 1)'(1) << SHIFT) >> 1;
    localparam logic signed [WW-1:0] YMAX = (WW'(1) <<< (OUT_W - 1)) - WW'(1);
    localparam logic signed [WW-1:0] YMIN = -YMAX - WW'(1);

    // Round half up, then arithmetic shift; one extra bit keeps the
    // rounding addition exact.
    function automatic logic signed [A:0] round_shift(input logic signed [A-1:0] s);
        logic signed [A:0] t;
        t = {s[A-1], s} + RND;
        return t >>> SHIFT;
    endfunction

    // Returns {sat_flag, clamped_value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [A:0] r);
        logic signed [WW-1:0] rw;
        rw = WW'(r);
        if (rw > YMAX)
            return {1'b1, OUT_W'(YMAX)};
        else if (rw < YMIN)
            return {1'b1, OUT_W'(YMIN)};
        else
            return {1'b0, OUT_W'(rw)};
    endfunction

    logic                  en;
    logic                  accept;
    logic                  load;
    logic [CW-1:0]         cnt_p0;
    logic                  last_p0;
    logic signed [P-1:0]   prod_p0;
    logic signed [P-1:0]   prod_p1;
    logic                  vld_p1;
    logic                  last_p1;
    logic signed [A-1:0]   sum_p1;
    logic signed [A-1:0]   acc_p2;
    logic signed [A:0]     scaled_p1;
    logic [OUT_W:0]        sat_res_p1;

    // A stalled result freezes the whole pipeline; s_ready never looks at s_valid.
    assign en      = ~(m_valid & ~m_ready);
    assign s_ready = en & ~flush;
    assign accept  = s_valid & s_ready;

    assign last_p0 = (cnt_p0 == CW'(N - 1));
    assign prod_p0 = P'(s_x) * P'(s_c);

    assign sum_p1     = acc_p2 + {{CW{prod_p1[P-1]}}, prod_p1};
    assign scaled_p1  = round_shift(sum_p1);
    assign sat_res_p1 = saturate(scaled_p1);

    // The last product of a vector goes straight to the output register
    // and restarts the accumulator, so the next vector needs no bubble.
    assign load = en & ~flush & vld_p1 & last_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0  <= '0;
            prod_p1 <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            acc_p2  <= '0;
            m_valid <= 1'b0;
            m_y     <= '0;
            m_sat   <= 1'b0;
        end else begin
            if (flush) begin
                cnt_p0  <= '0;
                vld_p1  <= 1'b0;
                last_p1 <= 1'b0;
                acc_p2  <= '0;
            end else if (en) begin
                // ---- stage 0 -> 1: beat capture and product ----
                if (accept) begin
                    prod_p1 <= prod_p0;
                    vld_p1  <= 1'b1;
                    last_p1 <= last_p0;
                    cnt_p0  <= last_p0 ? '0 : cnt_p0 + 1'b1;
                end else begin
                    vld_p1  <= 1'b0;
                end
                // ---- stage 1 -> 2: accumulate ----
                if (vld_p1)
                    acc_p2 <= last_p1 ? '0 : sum_p1;
            end

            // ---- stage 2 -> output register ----
            if (load) begin
                m_valid <= 1'b1;
                m_y     <= sat_res_p1[OUT_W-1:0];
                m_sat   <= sat_res_p1[OUT_W];
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dst_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_dst_mac_seq
//   Drives two instances of dst_mac_seq with identical stimulus: one with
//   default parameters and one with OUT_W=16, SHIFT=4. Results are compared
//   against a dot-product reference model computed directly from the beats.
// -----------------------------------------------------------------------------
module tb_dst_mac_seq;

    localparam int IN_W = 12;
    localparam int CW_W = 8;
    localparam int NT   = 4;
    localparam int OW0  = IN_W + CW_W + 2;
    localparam int SH0  = 0;
    localparam int OW1  = 16;
    localparam int SH1  = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic s_valid;
    logic m_ready;
    logic signed [IN_W-1:0] s_x;
    logic signed [CW_W-1:0] s_c;

    logic s_ready0, m_valid0, m_sat0;
    logic signed [OW0-1:0] m_y0;
    logic s_ready1, m_valid1, m_sat1;
    logic signed [OW1-1:0] m_y1;

    always #5 clk = ~clk;

    dst_mac_seq #(.IN_W(IN_W), .COEFF_W(CW_W), .N(NT), .SHIFT(SH0), .OUT_W(OW0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready0), .s_x(s_x), .s_c(s_c),
        .m_valid(m_valid0), .m_ready(m_ready), .m_y(m_y0), .m_sat(m_sat0)
    );

    dst_mac_seq #(.IN_W(IN_W), .COEFF_W(CW_W), .N(NT), .SHIFT(SH1), .OUT_W(OW1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready1), .s_x(s_x), .s_c(s_c),
        .m_valid(m_valid1), .m_ready(m_ready), .m_y(m_y1), .m_sat(m_sat1)
    );

    int checks = 0;
    int errors = 0;
    int nres   = 0;

    longint xb[$];
    longint cb[$];
    longint q0_y[$];
    bit     q0_s[$];
    longint q1_y[$];
    bit     q1_s[$];

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scale with round-half-up (floor of (sum + half)/2^sh), then clamp.
    function automatic void ref_out(input longint sum, input int sh, input int ow,
                                    output longint y, output bit sat);
        longint num, d, r, hi, lo;
        if (sh > 0) begin
            d   = longint'(1) << sh;
            num = sum + d / 2;
            r   = num / d;
            if ((num % d != 0) && (num < 0)) r = r - 1;
        end else begin
            r = sum;
        end
        hi = (longint'(1) << (ow - 1)) - 1;
        lo = -hi - 1;
        sat = 1'b0;
        y   = r;
        if (r > hi) begin y = hi; sat = 1'b1; end
        if (r < lo) begin y = lo; sat = 1'b1; end
    endfunction

    task automatic model_beat(input longint x, input longint c);
        longint sum, y;
        bit     sat;
        xb.push_back(x);
        cb.push_back(c);
        if (xb.size() == NT) begin
            sum = 0;
            for (int k = 0; k < NT; k++) sum += xb[k] * cb[k];
            ref_out(sum, SH0, OW0, y, sat);
            q0_y.push_back(y); q0_s.push_back(sat);
            ref_out(sum, SH1, OW1, y, sat);
            q1_y.push_back(y); q1_s.push_back(sat);
            xb.delete();
            cb.delete();
        end
    endtask

    // One clock cycle: drive at the falling edge, observe 1 ns later, and
    // account for the handshakes that complete on the next rising edge.
    task automatic cyc(input bit sv, input logic signed [IN_W-1:0] x,
                       input logic signed [CW_W-1:0] c, input bit mr, input bit fl);
        @(negedge clk);
        s_valid = sv; s_x = x; s_c = c; m_ready = mr; flush = fl;
        #1;
        if (m_valid0 && mr) begin
            nres++;
            if (q0_y.size() == 0) chk("dut0_extra_result", q0_y.size(), 1);
            else begin
                chk("dut0_y",   $signed(m_y0), q0_y.pop_front());
                chk("dut0_sat", m_sat0,        q0_s.pop_front());
            end
        end
        if (m_valid1 && mr) begin
            if (q1_y.size() == 0) chk("dut1_extra_result", q1_y.size(), 1);
            else begin
                chk("dut1_y",   $signed(m_y1), q1_y.pop_front());
                chk("dut1_sat", m_sat1,        q1_s.pop_front());
            end
        end
        if (sv && s_ready0) model_beat(longint'(x), longint'(c));
        if (fl) begin xb.delete(); cb.delete(); end
    endtask

    task automatic idle(input bit mr);
        cyc(1'b0, IN_W'($urandom), CW_W'($urandom), mr, 1'b0);
    endtask

    task automatic send_vec(input int x0, input int x1, input int x2, input int x3,
                            input int c0, input int c1, input int c2, input int c3);
        cyc(1'b1, IN_W'(x0), CW_W'(c0), 1'b1, 1'b0);
        cyc(1'b1, IN_W'(x1), CW_W'(c1), 1'b1, 1'b0);
        cyc(1'b1, IN_W'(x2), CW_W'(c2), 1'b1, 1'b0);
        cyc(1'b1, IN_W'(x3), CW_W'(c3), 1'b1, 1'b0);
    endtask

    // Last beat was in the previous cycle T: nothing at T+1, result at T+2.
    task automatic expect_result(input string tag, input longint y0, input bit s0,
                                 input longint y1, input bit s1);
        idle(1'b1);
        chk({tag, "_valid_t1"}, m_valid0, 0);
        idle(1'b1);
        chk({tag, "_valid_t2"}, m_valid0, 1);
        chk({tag, "_y0"},   $signed(m_y0), y0);
        chk({tag, "_sat0"}, m_sat0, s0);
        chk({tag, "_y1"},   $signed(m_y1), y1);
        chk({tag, "_sat1"}, m_sat1, s1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bi;
        int n0;
        bit sv;
        bit fl;
        bit mr;

        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        s_x = '0; s_c = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_valid", m_valid0, 0);
        chk("rst_m_y",     $signed(m_y0), 0);
        chk("rst_m_sat",   m_sat0, 0);
        chk("rst_s_ready", s_ready0, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic vector and latency
        send_vec(1, 2, 3, 4, 5, 6, 7, 8);
        expect_result("basic", 70, 0, 4, 0);

        // Extremes
        send_vec(-2048, -2048, -2048, -2048, -128, -128, -128, -128);
        expect_result("ext_pos", 1048576, 0, 32767, 1);
        send_vec(2047, 2047, 2047, 2047, -128, -128, -128, -128);
        expect_result("ext_neg", -1048064, 0, -32768, 1);

        // Negated coefficients: rounding toward +inf on the half-up rule
        send_vec(1, 2, 3, 4, -5, -6, -7, -8);
        expect_result("neg", -70, 0, -4, 0);

        // Backpressure: three back-to-back vectors, m_ready low 5 cycles
        // starting at the first result.
        bi = 0;
        n0 = nres;
        for (int t = 0; t < 100; t++) begin
            mr = !(t >= 5 && t < 10);
            sv = (bi < 12);
            cyc(sv, IN_W'((bi % 4) + 1), CW_W'(((bi / 4) == 1) ? -((bi % 4) + 5) : ((bi % 4) + 5)),
                mr, 1'b0);
            if (t == 5) chk("bp_first_valid", m_valid0, 1);
            if (t >= 5 && t < 10) chk("bp_s_ready_low", s_ready0, 0);
            if (sv && s_ready0) bi++;
            if (bi == 12 && q0_y.size() == 0 && t > 12) break;
        end
        chk("bp_beats_sent", bi, 12);
        chk("bp_results", nres - n0, 3);

        // Flush after two beats, then a full vector
        cyc(1'b1, 12'sd9, 8'sd9, 1'b1, 1'b0);
        cyc(1'b1, 12'sd9, 8'sd9, 1'b1, 1'b0);
        cyc(1'b1, 12'sd100, 8'sd100, 1'b1, 1'b1);
        chk("flush_s_ready", s_ready0, 0);
        send_vec(1, 2, 3, 4, 5, 6, 7, 8);
        expect_result("after_flush", 70, 0, 4, 0);

        // Flush while a result is pending
        send_vec(1, 2, 3, 4, 5, 6, 7, 8);
        idle(1'b0);
        idle(1'b0);
        chk("pend_valid", m_valid0, 1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        chk("pend_valid_in_flush", m_valid0, 1);
        idle(1'b0);
        chk("pend_valid_after_flush", m_valid0, 1);
        chk("pend_y", $signed(m_y0), 70);
        n0 = nres;
        idle(1'b1);
        chk("pend_delivered", nres - n0, 1);

        // Reset in the middle of a vector, with a stale 70 still on m_y
        cyc(1'b1, 12'sd1, 8'sd5, 1'b1, 1'b0);
        cyc(1'b1, 12'sd2, 8'sd6, 1'b1, 1'b0);
        cyc(1'b1, 12'sd3, 8'sd7, 1'b1, 1'b0);
        chk("pre_rst_m_y", $signed(m_y0), 70);
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid0, 0);
        chk("mid_rst_m_y",     $signed(m_y0), 0);
        chk("mid_rst_m_y1",    $signed(m_y1), 0);
        xb.delete(); cb.delete();
        q0_y.delete(); q0_s.delete(); q1_y.delete(); q1_s.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_s_ready", s_ready0, 1);
        send_vec(1, 2, 3, 4, 5, 6, 7, 8);
        expect_result("post_rst", 70, 0, 4, 0);

        // Randomized traffic with gaps, backpressure and occasional flush
        for (int t = 0; t < 400; t++) begin
            sv = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 3) != 0);
            fl = (xb.size() > 0) && ($urandom_range(0, 39) == 0);
            cyc(sv, IN_W'($urandom), CW_W'($urandom), mr, fl);
        end
        for (int t = 0; t < 50; t++) begin
            if (q0_y.size() == 0 && q1_y.size() == 0) break;
            idle(1'b1);
        end
        chk("drain_q0_empty", q0_y.size(), 0);
        chk("drain_q1_empty", q1_y.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
